seq_det_ctrl: RTL and testbench
===============================

Name: seq_det_ctrl

Overview:
- Programmable serial-pattern detection controller for the team's bit-stream detectors.
- Holds a configurable pattern, length and overlap mode, and sequences a detection run over a fixed bit window.
- Counts matches, flags a threshold hit, and signals window completion.
- Sits between a config/control master and a gated serial input (x, x_valid).

Parameters:
PAT_W, 8, maximum pattern length in bits (2..15)
CNT_W, 8, match counter width
WIN_W, 16, window length counter width

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
cfg_we  in  1  config write strobe (honoured only in IDLE)
cfg_pat  in  PAT_W  pattern; bit [len-1] expected first, bit [0] last
cfg_len  in  4  pattern length; 0 treated as 1, >PAT_W treated as PAT_W
cfg_ovl  in  1  1 = overlapping matches allowed
cfg_win  in  WIN_W  bits per run; 0 = unbounded (run until abort)
cfg_thr  in  CNT_W  match threshold for hit; 0 disables hit
start  in  1  begin run (honoured only in IDLE)
abort  in  1  terminate run, no done
x_valid  in  1  x is valid this cycle
x  in  1  serial data bit
busy  out  1  high in RUN and DONE
match  out  1  one-cycle pulse per detected match
done  out  1  one-cycle pulse at window end
hit  out  1  sticky: match_cnt reached cfg_thr during the run
match_cnt  out  CNT_W  matches in current/last run, saturating

Behaviour:
- Reset (rst=1 at edge): state IDLE; config registers pat=0, len=1, ovl=0, win=0, thr=0; hist=0, fill=0, bitcnt=0; all outputs 0.
- Config registers:
  - Written on cfg_we in IDLE only; cfg_we in RUN/DONE is ignored.
  - cfg_we together with start in IDLE: the write takes effect, and the run uses the newly written values.
- FSM:
  - IDLE -> RUN on start. Clears hist, fill, bitcnt, match_cnt and hit.
  - RUN -> DONE on the sampling edge where bitcnt+1 == win (win != 0).
  - DONE -> IDLE unconditionally after 1 cycle. done=1 only while in DONE.
  - abort in RUN or DONE -> IDLE at that edge. No done, no match on that edge; match_cnt and hit hold their values.
  - start while busy is ignored.
- Sampling in RUN, edge with x_valid=1 (x_valid=0 means no state change except abort):
  - hist <= {hist[PAT_W-2:0], x}
  - fill <= min(fill+1, PAT_W)
  - bitcnt increments
- Match condition: (fill+1) >= len and {hist, x}[len-1:0] == pat[len-1:0].
  - Evaluated on the pre-edge values of hist and fill together with the current x.
- On a match:
  - match registered high for the cycle following the sampling edge; zero extra latency beyond one register.
  - match_cnt increments, saturating at all-ones.
  - ovl=0: fill cleared to 0 at the same edge, so the next match needs len fresh bits.
  - ovl=1: fill continues normally.
- hit: set at the edge where the updated match_cnt == thr (thr != 0); stays set until next start or rst.
- The bit that ends the window is still checked for a match; match and done may overlap (match in the same cycle as DONE).
- Bits with x_valid in DONE or IDLE are ignored.
- rst mid-run overrides everything: IDLE, counters cleared, config returns to reset values.
- match_cnt and hit stay readable in IDLE until the next start.

Test Plan:
1. pat=3'b001, len=3, ovl=0, win=6, start; bits 0,0,1,0,0,1 on consecutive cycles -> match pulses after bit 3 and bit 6, match_cnt=2, done high 1 cycle after bit 6, busy falls the cycle after done.
2. pat=2'b11, len=2, win=3, bits 1,1,1 -> ovl=1: 2 matches, match_cnt=2; ovl=0: 1 match (after bit 2), match_cnt=1.
3. thr=2, pattern as in test 1, win=0, stream 001001001 -> hit rises with the 2nd match and stays high; match_cnt=3; no done; abort -> IDLE with match_cnt=3 held.
4. win=4 with x_valid gaps (valid on cycles 1,3,4,7) and extra valid bits after the window -> done only after the 4th valid bit; later bits do not change match_cnt; cfg_we during RUN does not change pat.
5. CNT_W=2, pat=1'b1, len=1, win=0, eight 1s -> match_cnt saturates at 3, match still pulses on every bit.
6. rst asserted mid-run after 2 matches -> next cycle busy=0, match_cnt=0, hit=0, len=1; start with no new config -> len=1, pat=0, so each valid 0 bit matches.

Source files
------------

// File: rtl/seq_det_ctrl.sv
// Programmable serial-pattern detection controller: holds pattern/length/overlap
// configuration, runs a detection window over gated serial bits and counts matches.
module seq_det_ctrl #(
  parameter int unsigned PAT_W = 8,
  parameter int unsigned CNT_W = 8,
  parameter int unsigned WIN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [PAT_W-1:0] cfg_pat,
  input  logic [3:0]       cfg_len,
  input  logic             cfg_ovl,
  input  logic [WIN_W-1:0] cfg_win,
  input  logic [CNT_W-1:0] cfg_thr,
  input  logic             start,
  input  logic             abort,
  input  logic             x_valid,
  input  logic             x,
  output logic             busy,
  output logic             match,
  output logic             done,
  output logic             hit,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int unsigned   FW       = $clog2(PAT_W + 1);
  localparam logic [FW-1:0] FILL_MAX = FW'(PAT_W);
  localparam logic [3:0]    LEN_MAX  = 4'(PAT_W);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [3:0]       len_q, len_d;
  logic             ovl_q, ovl_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [CNT_W-1:0] thr_q, thr_d;
  logic [PAT_W-1:0] hist_q, hist_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic [WIN_W-1:0] bitcnt_q, bitcnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hit_q, hit_d;
  logic             match_q, match_d;

  logic [3:0]       len_w;
  logic [PAT_W-1:0] shifted;
  logic [PAT_W-1:0] mask;
  logic [4:0]       fill_p1;
  logic             pat_hit;
  logic [FW-1:0]    fill_inc;
  logic [CNT_W-1:0] cnt_inc;
  logic             win_end;

  // Length is clamped once at write time so the datapath only sees 1..PAT_W.
  always_comb begin
    len_w = cfg_len;
    if (cfg_len == 4'd0) begin
      len_w = 4'd1;
    end else if (cfg_len > LEN_MAX) begin
      len_w = LEN_MAX;
    end
  end

  always_comb begin
    shifted = {hist_q[PAT_W-2:0], x};
    mask    = '0;
    for (int unsigned i = 0; i < PAT_W; i++) begin
      mask[i] = (i < 32'(len_q));
    end
    fill_p1  = 5'(fill_q) + 5'd1;
    pat_hit  = (fill_p1 >= {1'b0, len_q}) && (((shifted ^ pat_q) & mask) == '0);
    fill_inc = (fill_q == FILL_MAX) ? fill_q : fill_q + FW'(1);
    cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    win_end  = (win_q != '0) && ((bitcnt_q + WIN_W'(1)) == win_q);
  end

  always_comb begin
    state_d  = state_q;
    pat_d    = pat_q;
    len_d    = len_q;
    ovl_d    = ovl_q;
    win_d    = win_q;
    thr_d    = thr_q;
    hist_d   = hist_q;
    fill_d   = fill_q;
    bitcnt_d = bitcnt_q;
    cnt_d    = cnt_q;
    hit_d    = hit_q;
    match_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (cfg_we) begin
          pat_d = cfg_pat;
          len_d = len_w;
          ovl_d = cfg_ovl;
          win_d = cfg_win;
          thr_d = cfg_thr;
        end
        if (start) begin
          state_d  = S_RUN;
          hist_d   = '0;
          fill_d   = '0;
          bitcnt_d = '0;
          cnt_d    = '0;
          hit_d    = 1'b0;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (x_valid) begin
          hist_d   = shifted;
          bitcnt_d = bitcnt_q + WIN_W'(1);
          fill_d   = fill_inc;
          if (pat_hit) begin
            match_d = 1'b1;
            cnt_d   = cnt_inc;
            if ((thr_q != '0) && (cnt_inc == thr_q)) begin
              hit_d = 1'b1;
            end
            if (!ovl_q) begin
              fill_d = '0;
            end
          end
          if (win_end) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pat_q    <= '0;
      len_q    <= 4'd1;
      ovl_q    <= 1'b0;
      win_q    <= '0;
      thr_q    <= '0;
      hist_q   <= '0;
      fill_q   <= '0;
      bitcnt_q <= '0;
      cnt_q    <= '0;
      hit_q    <= 1'b0;
      match_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pat_q    <= pat_d;
      len_q    <= len_d;
      ovl_q    <= ovl_d;
      win_q    <= win_d;
      thr_q    <= thr_d;
      hist_q   <= hist_d;
      fill_q   <= fill_d;
      bitcnt_q <= bitcnt_d;
      cnt_q    <= cnt_d;
      hit_q    <= hit_d;
      match_q  <= match_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign match     = match_q;
  assign hit       = hit_q;
  assign match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Self-checking bench for seq_det_ctrl: table vectors, hand sequences and random
// stimulus against a bit-history reference model.
module tb_seq_det_ctrl;

  logic        clk = 1'b0;
  logic        rst, cfg_we, cfg_ovl, start, abort, x_valid, x;
  logic [7:0]  cfg_pat, cfg_thr;
  logic [3:0]  cfg_len;
  logic [15:0] cfg_win;
  logic        busy, match, done, hit;
  logic [7:0]  match_cnt;
  logic        busy2, match2, done2, hit2;
  logic [1:0]  match_cnt2;

  always #5 clk = ~clk;

  seq_det_ctrl dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pat(cfg_pat), .cfg_len(cfg_len),
    .cfg_ovl(cfg_ovl), .cfg_win(cfg_win), .cfg_thr(cfg_thr), .start(start),
    .abort(abort), .x_valid(x_valid), .x(x), .busy(busy), .match(match),
    .done(done), .hit(hit), .match_cnt(match_cnt)
  );

  seq_det_ctrl #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pat(cfg_pat), .cfg_len(cfg_len),
    .cfg_ovl(cfg_ovl), .cfg_win(cfg_win), .cfg_thr(cfg_thr[1:0]), .start(start),
    .abort(abort), .x_valid(x_valid), .x(x), .busy(busy2), .match(match2),
    .done(done2), .hit(hit2), .match_cnt(match_cnt2)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int ndone, nmatch2;

  // Reference model: mode 0 idle, 1 run, 2 done; bits seen since run start
  // (or since the last match when overlap is off).
  int       m_mode, m_len, m_win, m_thr, m_bits, m_cnt, m_cnt2;
  bit [7:0] m_pat;
  bit       m_ovl, m_hit, m_match;
  bit       q[$];

  task automatic check(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic bit model_matches();
    if (q.size() < m_len) return 1'b0;
    for (int i = 0; i < m_len; i++)
      if (q[q.size() - 1 - i] != m_pat[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step();
    if (rst) begin
      m_mode = 0; m_pat = 0; m_len = 1; m_ovl = 0; m_win = 0; m_thr = 0;
      q.delete(); m_bits = 0; m_cnt = 0; m_cnt2 = 0; m_hit = 0; m_match = 0;
      return;
    end
    m_match = 0;
    case (m_mode)
      0: begin
        if (cfg_we) begin
          m_pat = cfg_pat;
          m_len = (cfg_len == 0) ? 1 : ((cfg_len > 8) ? 8 : int'(cfg_len));
          m_ovl = cfg_ovl; m_win = cfg_win; m_thr = cfg_thr;
        end
        if (start) begin
          m_mode = 1; q.delete(); m_bits = 0; m_cnt = 0; m_cnt2 = 0; m_hit = 0;
        end
      end
      1: begin
        if (abort) m_mode = 0;
        else if (x_valid) begin
          q.push_back(x);
          if (q.size() > 16) void'(q.pop_front());
          m_bits++;
          if (model_matches()) begin
            m_match = 1;
            if (m_cnt < 255) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
            if (m_thr != 0 && m_cnt == m_thr) m_hit = 1;
            if (!m_ovl) q.delete();
          end
          if (m_win != 0 && m_bits == m_win) m_mode = 2;
        end
      end
      default: m_mode = 0;
    endcase
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("busy", busy, m_mode != 0);
    check("done", done, m_mode == 2);
    check("match", match, m_match);
    check("hit", hit, m_hit);
    check("match_cnt", match_cnt, m_cnt);
    check("match2", match2, m_match);
    check("match_cnt2", match_cnt2, m_cnt2);
    if (done) ndone++;
    if (match2) nmatch2++;
  endtask

  task automatic idle_inputs();
    rst = 0; cfg_we = 0; start = 0; abort = 0; x_valid = 0; x = 0;
  endtask

  task automatic config_start(logic [7:0] p, logic [3:0] l, logic o,
                              logic [15:0] w, logic [7:0] t);
    cfg_pat = p; cfg_len = l; cfg_ovl = o; cfg_win = w; cfg_thr = t;
    cfg_we = 1; start = 1;
    cycle();
    cfg_we = 0; start = 0;
    ndone = 0; nmatch2 = 0;
  endtask

  task automatic feed(logic b);
    x_valid = 1; x = b;
    cycle();
    x_valid = 0;
  endtask

  typedef struct {
    logic [7:0]  pat;
    logic [3:0]  len;
    logic        ovl;
    logic [15:0] win;
    logic [7:0]  thr;
    int          nbits;
    logic [15:0] bits;
    int          exp_cnt;
    int          exp_hit;
    int          exp_done;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{8'h01, 4'd3,  1'b0, 16'd6, 8'd0, 6, 16'b001001,    2, 0, 1};
    vecs[1] = '{8'h03, 4'd2,  1'b1, 16'd3, 8'd0, 3, 16'b111,       2, 0, 1};
    vecs[2] = '{8'h03, 4'd2,  1'b0, 16'd3, 8'd0, 3, 16'b111,       1, 0, 1};
    vecs[3] = '{8'h01, 4'd3,  1'b0, 16'd0, 8'd2, 9, 16'b001001001, 3, 1, 0};
    vecs[4] = '{8'h01, 4'd0,  1'b0, 16'd4, 8'd0, 4, 16'b1011,      3, 0, 1};
    vecs[5] = '{8'hA5, 4'd15, 1'b0, 16'd8, 8'd1, 8, 16'b10100101,  1, 1, 1};
    vecs[6] = '{8'h05, 4'd3,  1'b1, 16'd5, 8'd0, 5, 16'b10101,     2, 0, 1};
    vecs[7] = '{8'h05, 4'd3,  1'b0, 16'd5, 8'd3, 5, 16'b10101,     1, 0, 1};

    idle_inputs();
    cfg_pat = 0; cfg_len = 0; cfg_ovl = 0; cfg_win = 0; cfg_thr = 0;
    rst = 1;
    cycle();
    rst = 0;
    check("reset_busy", busy, 0);
    check("reset_cnt", match_cnt, 0);

    foreach (vecs[k]) begin
      config_start(vecs[k].pat, vecs[k].len, vecs[k].ovl, vecs[k].win, vecs[k].thr);
      for (int i = 0; i < vecs[k].nbits; i++) feed(vecs[k].bits[vecs[k].nbits - 1 - i]);
      cycle(); cycle();
      if (vecs[k].win == 0) begin
        abort = 1; cycle(); abort = 0;
      end
      check($sformatf("vec%0d_cnt", k), match_cnt, vecs[k].exp_cnt);
      check($sformatf("vec%0d_hit", k), hit, vecs[k].exp_hit);
      check($sformatf("vec%0d_done", k), ndone, vecs[k].exp_done);
      check($sformatf("vec%0d_busy", k), busy, 0);
    end

    // x_valid gaps, cfg_we during RUN, valid bits after the window
    config_start(8'h01, 4'd1, 1'b0, 16'd4, 8'd0);
    for (int c = 1; c <= 7; c++) begin
      x_valid = (c == 1 || c == 3 || c == 4 || c == 7); x = 1;
      cfg_we = (c == 2); cfg_pat = 8'h00;
      cycle();
    end
    cfg_we = 0;
    for (int c = 0; c < 3; c++) feed(1'b1);
    check("gap_cnt", match_cnt, 4);
    check("gap_done", ndone, 1);

    // 2-bit counter saturation on the narrow instance
    config_start(8'h01, 4'd1, 1'b0, 16'd0, 8'd0);
    for (int i = 0; i < 8; i++) feed(1'b1);
    check("sat_cnt2", match_cnt2, 3);
    check("sat_pulses2", nmatch2, 8);
    abort = 1; cycle(); abort = 0;

    // reset mid-run, then restart on reset-default config
    config_start(8'h01, 4'd3, 1'b1, 16'd0, 8'd1);
    feed(0); feed(0); feed(1); feed(0); feed(0); feed(1);
    check("pre_rst_cnt", match_cnt, 2);
    check("pre_rst_hit", hit, 1);
    rst = 1; cycle(); rst = 0;
    check("rst_busy", busy, 0);
    check("rst_cnt", match_cnt, 0);
    check("rst_hit", hit, 0);
    start = 1; cycle(); start = 0;
    feed(0); feed(0); feed(0);
    check("default_cfg_cnt", match_cnt, 3);
    abort = 1; cycle(); abort = 0;

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      rst     = ($urandom_range(0, 199) == 0);
      cfg_we  = ($urandom_range(0, 9) == 0);
      cfg_pat = 8'($urandom);
      cfg_len = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 4));
      cfg_ovl = 1'($urandom_range(0, 1));
      cfg_win = 16'($urandom_range(0, 24));
      cfg_thr = 8'($urandom_range(0, 4));
      start   = ($urandom_range(0, 7) == 0);
      abort   = ($urandom_range(0, 59) == 0);
      x_valid = ($urandom_range(0, 9) < 7);
      x       = 1'($urandom_range(0, 1));
      cycle();
    end
    idle_inputs();
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
